// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: grant encoding and defaults for the RAM bus arbiter.
// Optional AMO lock: RAM_ARB_AMO_LOCK_EN. Tag macros fall back when tags.svh is absent.
`ifndef ADDR_TAG_BITS
`define ADDR_TAG_BITS 4
`endif
`ifndef ADDR_TAG_MODE_MASK
`define ADDR_TAG_MODE_MASK 4'b0011
`endif
`ifndef ADDR_TAG_MODE_AMO
`define ADDR_TAG_MODE_AMO 4'b0010
`endif

package ram_arb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_M0   = 2'b01,
        GNT_M1   = 2'b10
    } grant_t;

    localparam int unsigned TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/ram_arb_watchdog.sv
// ram_arb_watchdog: counts stalled strobe cycles on the RAM bus and
// flags expiry one cycle after the limit is reached (0 = disabled).
module ram_arb_watchdog
    import ram_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic stb,
    input  logic ack,
    input  logic restart,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused;
            assign unused  = ^{clk, rst, stb, ack, restart};
            assign expired = 1'b0;
        end else begin : g_on
            localparam int W = $clog2(TIMEOUT_CYCLES + 1);
            logic [W-1:0] count;
            logic         pending;

            // count stalled cycles; arm the forced ack when the limit is hit
            always_ff @(posedge clk) begin
                if (rst || restart || !stb || ack) begin
                    count   <= '0;
                    pending <= 1'b0;
                end else begin
                    pending <= (count == W'(TIMEOUT_CYCLES - 1));
                    count   <= count + 1'b1;
                end
            end

            assign expired = pending;
        end
    endgenerate

endmodule

// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: two-master Wishbone arbiter in front of the RAM bus.
// Optional AMO lock keeps master 1 granted across RMW: RAM_ARB_AMO_LOCK_EN.
module ram_bus_arbiter
    import ram_arb_pkg::*;
#(
    parameter int          ROUND_ROBIN    = 1,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      m0_cyc_i,
    input  logic                      m0_stb_i,
    input  logic                      m0_we_i,
    input  logic [3:0]                m0_sel_i,
    input  logic [31:0]               m0_addr_i,
    input  logic [`ADDR_TAG_BITS-1:0] m0_addr_tag_i,
    input  logic [31:0]               m0_data_i,
    output logic                      m0_ack_o,
    output logic [31:0]               m0_data_o,
    output logic                      m0_data_tag_o,
    input  logic                      m1_cyc_i,
    input  logic                      m1_stb_i,
    input  logic                      m1_we_i,
    input  logic [3:0]                m1_sel_i,
    input  logic [31:0]               m1_addr_i,
    input  logic [`ADDR_TAG_BITS-1:0] m1_addr_tag_i,
    input  logic [31:0]               m1_data_i,
    output logic                      m1_ack_o,
    output logic [31:0]               m1_data_o,
    output logic                      m1_data_tag_o,
    output logic                      cyc_o,
    output logic                      stb_o,
    output logic                      we_o,
    output logic [3:0]                sel_o,
    output logic [31:0]               addr_o,
    output logic [`ADDR_TAG_BITS-1:0] addr_tag_o,
    output logic [31:0]               data_o,
    input  logic                      ack_i,
    input  logic [31:0]               data_i,
    input  logic                      data_tag_i,
    output logic                      bus_err_o,
    output logic [1:0]                grant_o
);

    grant_t grant;
    grant_t winner;
    logic   last;
    logic   req0;
    logic   req1;
    logic   owner_cyc;
    logic   lock_hold;
    logic   arb_en;
    logic   restart;
    logic   expired;
    logic   force_ack;
    logic   ack_eff;
    logic   own0;
    logic   own1;

    assign req0      = m0_cyc_i & m0_stb_i;
    assign req1      = m1_cyc_i & m1_stb_i;
    assign own0      = (grant == GNT_M0);
    assign own1      = (grant == GNT_M1);
    assign owner_cyc = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
    assign force_ack = expired & ~ack_i;
    assign ack_eff   = ack_i | force_ack;

    // pick the next owner among current requesters
    always_comb begin
        winner = GNT_NONE;
        if (req0 && req1) begin
            winner = (ROUND_ROBIN != 0 && last) ? GNT_M0 : GNT_M1;
        end else if (req1) begin
            winner = GNT_M1;
        end else if (req0) begin
            winner = GNT_M0;
        end
    end

`ifdef RAM_ARB_AMO_LOCK_EN
    logic lock;
    logic m1_amo;
    logic lock_set;
    logic lock_clr;

    assign m1_amo   = ((m1_addr_tag_i & `ADDR_TAG_MODE_MASK)
                       == `ADDR_TAG_MODE_AMO);
    assign lock_set = ack_i & own1 & m1_stb_i & ~m1_we_i & m1_amo;
    assign lock_clr = lock & (force_ack
                      | (ack_i & own1 & m1_stb_i & m1_we_i & m1_amo));
    assign lock_hold = lock_set | (lock & ~lock_clr);

    // hold master 1 between the AMO read and its write-back
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock <= 1'b0;
        end else if (lock_set) begin
            lock <= 1'b1;
        end else if (lock_clr) begin
            lock <= 1'b0;
        end
    end
`else
    assign lock_hold = 1'b0;
`endif

    assign arb_en  = ((grant == GNT_NONE) | ~owner_cyc) & ~lock_hold;
    assign restart = arb_en & (winner != grant);

    // registered grant and last-served history
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant <= GNT_NONE;
            last  <= 1'b0;
        end else if (arb_en) begin
            grant <= winner;
            if (winner != GNT_NONE) begin
                last <= (winner == GNT_M1);
            end
        end
    end

    ram_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (clk_i),
        .rst     (rst_i),
        .stb     (stb_o),
        .ack     (ack_eff),
        .restart (restart),
        .expired (expired)
    );

    // steer the owner's request onto the RAM bus; zero while idle
    always_comb begin
        cyc_o      = 1'b0;
        stb_o      = 1'b0;
        we_o       = 1'b0;
        sel_o      = '0;
        addr_o     = '0;
        addr_tag_o = '0;
        data_o     = '0;
        unique case (grant)
            GNT_M0: begin
                cyc_o      = m0_cyc_i;
                stb_o      = m0_stb_i;
                we_o       = m0_we_i;
                sel_o      = m0_sel_i;
                addr_o     = m0_addr_i;
                addr_tag_o = m0_addr_tag_i;
                data_o     = m0_data_i;
            end
            GNT_M1: begin
                cyc_o      = m1_cyc_i;
                stb_o      = m1_stb_i;
                we_o       = m1_we_i;
                sel_o      = m1_sel_i;
                addr_o     = m1_addr_i;
                addr_tag_o = m1_addr_tag_i;
                data_o     = m1_data_i;
            end
            default: ;
        endcase
    end

    assign m0_ack_o      = ack_eff & own0 & m0_stb_i;
    assign m1_ack_o      = ack_eff & own1 & m1_stb_i;
    assign m0_data_o     = (own0 & ~force_ack) ? data_i : 32'h0;
    assign m1_data_o     = (own1 & ~force_ack) ? data_i : 32'h0;
    assign m0_data_tag_o = own0 & ~force_ack & data_tag_i;
    assign m1_data_tag_o = own1 & ~force_ack & data_tag_i;
    assign bus_err_o     = force_ack;
    assign grant_o       = grant;

endmodule
